// File: rtl/hamming72_encoder_tx.sv
// SECDED (72,64) transmit encoder with send/acknowledge/retry control.
// A 64-bit word is accepted in IDLE, encoded into a Hamming (72,64) codeword
// (parity at power-of-two positions, overall even parity at bit 0), strobed
// onto the link and retransmitted on receiver resend or timeout until
// MAX_RETRY retransmissions are used up, after which the block parks in FAIL.
// Optional build macro FAULT_INJECT_EN adds inj_mask, XORed into the first
// send of each word only.
module hamming72_encoder_tx #(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [63:0]                      data_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [71:0]                      code_out,
    output logic                             sendout,
    input  logic                             rx_ready,
    input  logic                             rx_resend,
    output logic                             done,
    output logic                             fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
`ifdef FAULT_INJECT_EN
    ,
    input  logic [71:0]                      inj_mask
`endif
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] MAX_R   = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENCODE,
        S_SEND,
        S_WAIT,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   data_q, data_d;
    logic [71:0]   code_q, code_d;
    logic          send_q, send_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [71:0]   enc_word;
`ifdef FAULT_INJECT_EN
    logic [71:0]   clean_q, clean_d;
`endif

    // Data bits fill non-power-of-two positions in ascending order; parity bit
    // 2^k covers every position whose index has bit k set; bit 0 makes the
    // whole word even parity.
    function automatic logic [71:0] encode72(input logic [63:0] d);
        logic [71:0] cw;
        logic        par;
        int          di;
        cw = '0;
        di = 0;
        for (int p = 3; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p[6:0]] = d[di[5:0]];
                di = di + 1;
            end
        end
        for (int k = 0; k < 7; k++) begin
            par = 1'b0;
            for (int p = 3; p < 72; p++) begin
                if (((p >> k) & 1) != 0) begin
                    par = par ^ cw[p[6:0]];
                end
            end
            cw[7'(1 << k)] = par;
        end
        cw[0] = ^cw[71:1];
        return cw;
    endfunction

    assign enc_word  = encode72(data_q);
    assign in_ready  = (state_q == S_IDLE);
    assign code_out  = code_q;
    assign sendout   = send_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

    // Next-state and next-register computation; timer_q == 0 marks the WAIT guard cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        code_d  = code_q;
        retry_d = retry_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        fail_d  = fail_q;
`ifdef FAULT_INJECT_EN
        clean_d = clean_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    retry_d = '0;
                    state_d = S_ENCODE;
                end
            end
            S_ENCODE: begin
`ifdef FAULT_INJECT_EN
                code_d  = enc_word ^ inj_mask;
                clean_d = enc_word;
`else
                code_d  = enc_word;
`endif
                state_d = S_SEND;
            end
            S_SEND: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if ((timer_q != '0) && rx_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (((timer_q != '0) && rx_resend) || (timer_q == TO_LAST)) begin
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + 1'b1;
`ifdef FAULT_INJECT_EN
                        code_d  = clean_q;
`endif
                        state_d = S_SEND;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = S_FAIL;
                    end
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        send_d = (state_d == S_SEND);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            code_q  <= '0;
            send_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            retry_q <= '0;
            timer_q <= '0;
`ifdef FAULT_INJECT_EN
            clean_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            code_q  <= code_d;
            send_q  <= send_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
`ifdef FAULT_INJECT_EN
            clean_q <= clean_d;
`endif
        end
    end

endmodule
